// File: rtl/id_stage.sv
// Registered RISC-V decode stage: owns the ID/EX pipeline register, resolves
// forwarding, load-use interlock, flush, redirects and illegal-opcode flagging.
module id_stage #(
    parameter int XLEN            = 32,
    parameter int INST_ADDR_W     = 32,
    parameter int LU_STALL_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_valid_i,
    output logic                   if_ready_o,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic [31:0]            inst_i,
    input  logic                   flush_i,
    input  logic                   ex_ready_i,
    input  logic                   ex_rmem_en_i,
    input  logic                   ex_wreg_en_i,
    input  logic                   mem_wreg_en_i,
    input  logic                   wb_wreg_en_i,
    input  logic [4:0]             ex_wreg_addr_i,
    input  logic [4:0]             mem_wreg_addr_i,
    input  logic [4:0]             wb_wreg_addr_i,
    input  logic [XLEN-1:0]        ex_wreg_data_i,
    input  logic [XLEN-1:0]        mem_wreg_data_i,
    input  logic [XLEN-1:0]        wb_wreg_data_i,
    output logic [4:0]             rs1_addr_o,
    output logic [4:0]             rs2_addr_o,
    input  logic [XLEN-1:0]        rs1_data_i,
    input  logic [XLEN-1:0]        rs2_data_i,
    output logic                   branch_o,
    output logic [INST_ADDR_W-1:0] branch_target_o,
    output logic                   id_valid_o,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [6:0]             opcode_o,
    output logic [2:0]             funct3_o,
    output logic [6:0]             funct7_o,
    output logic [XLEN-1:0]        imm_o,
    output logic                   wreg_en_o,
    output logic [4:0]             wreg_addr_o,
    output logic [XLEN-1:0]        rs1_data_o,
    output logic [XLEN-1:0]        rs2_data_o,
    output logic                   wmem_en_o,
    output logic                   rmem_en_o,
    output logic                   illegal_o
);

    typedef enum logic [4:0] {
        OP_LOAD    = 5'b00000,
        OP_STORE   = 5'b01000,
        OP_ALU_IMM = 5'b00100,
        OP_ALU_REG = 5'b01100,
        OP_LUI     = 5'b01101,
        OP_AUIPC   = 5'b00101,
        OP_JAL     = 5'b11011,
        OP_JALR    = 5'b11001,
        OP_BRANCH  = 5'b11000
    } op_group_e;

    localparam logic [2:0] LU_RELOAD = 3'(LU_STALL_CYCLES - 1);

    logic            quad_ok;
    logic [4:0]      opc;
    logic [2:0]      funct3;
    logic            is_load, is_store, is_alu_imm, is_alu_reg, is_lui;
    logic            is_auipc, is_jal, is_jalr, is_branch;
    logic            illegal;
    logic            wreg_en;
    logic            use_rs1, use_rs2;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic [XLEN-1:0] jalr_sum;
    logic            cond, taken;
    logic            hazard, stall, out_ready, fire;
    logic [2:0]      stall_cnt;

    assign quad_ok    = (inst_i[1:0] == 2'b11);
    assign opc        = inst_i[6:2];
    assign funct3     = inst_i[14:12];
    assign rs1_addr_o = inst_i[19:15];
    assign rs2_addr_o = inst_i[24:20];

    assign is_load    = quad_ok && (opc == OP_LOAD);
    assign is_store   = quad_ok && (opc == OP_STORE);
    assign is_alu_imm = quad_ok && (opc == OP_ALU_IMM);
    assign is_alu_reg = quad_ok && (opc == OP_ALU_REG);
    assign is_lui     = quad_ok && (opc == OP_LUI);
    assign is_auipc   = quad_ok && (opc == OP_AUIPC);
    assign is_jal     = quad_ok && (opc == OP_JAL);
    assign is_jalr    = quad_ok && (opc == OP_JALR);
    assign is_branch  = quad_ok && (opc == OP_BRANCH);

    // funct3 010/011 has no branch encoding, so it is treated like an unknown opcode
    assign illegal = ~(is_load | is_store | is_alu_imm | is_alu_reg | is_lui |
                       is_auipc | is_jal | is_jalr | is_branch) |
                     (is_branch & (funct3[2:1] == 2'b01));

    assign wreg_en = ~illegal & (is_alu_reg | is_alu_imm | is_load | is_jalr |
                                 is_lui | is_auipc | is_jal);
    assign use_rs1 = is_alu_reg | is_alu_imm | is_load | is_store | is_branch | is_jalr;
    assign use_rs2 = is_alu_reg | is_store | is_branch;

    always_comb begin
        imm32 = 32'd0;
        if (is_load || is_alu_imm || is_jalr)
            imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        else if (is_store)
            imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        else if (is_branch)
            imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        else if (is_lui || is_auipc)
            imm32 = {inst_i[31:12], 12'd0};
        else if (is_jal)
            imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    end

    generate
        if (XLEN > 32) begin : g_imm_wide
            assign imm = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_imm_narrow
            assign imm = imm32;
        end
    endgenerate

    function automatic logic [XLEN-1:0] forward(
        input logic [4:0]      src,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_en,
        input logic [4:0]      ex_addr,
        input logic [XLEN-1:0] ex_data,
        input logic            mem_en,
        input logic [4:0]      mem_addr,
        input logic [XLEN-1:0] mem_data,
        input logic            wb_en,
        input logic [4:0]      wb_addr,
        input logic [XLEN-1:0] wb_data
    );
        if (src == 5'd0)                      return '0;
        else if (ex_en && ex_addr == src)     return ex_data;
        else if (mem_en && mem_addr == src)   return mem_data;
        else if (wb_en && wb_addr == src)     return wb_data;
        else                                  return rf_data;
    endfunction

    assign rs1_fwd = forward(rs1_addr_o, rs1_data_i,
                             ex_wreg_en_i, ex_wreg_addr_i, ex_wreg_data_i,
                             mem_wreg_en_i, mem_wreg_addr_i, mem_wreg_data_i,
                             wb_wreg_en_i, wb_wreg_addr_i, wb_wreg_data_i);
    assign rs2_fwd = forward(rs2_addr_o, rs2_data_i,
                             ex_wreg_en_i, ex_wreg_addr_i, ex_wreg_data_i,
                             mem_wreg_en_i, mem_wreg_addr_i, mem_wreg_data_i,
                             wb_wreg_en_i, wb_wreg_addr_i, wb_wreg_data_i);

    always_comb begin
        cond = 1'b0;
        case (funct3[2:1])
            2'b00:   cond = (rs1_fwd == rs2_fwd);
            2'b10:   cond = ($signed(rs1_fwd) < $signed(rs2_fwd));
            2'b11:   cond = (rs1_fwd < rs2_fwd);
            default: cond = 1'b0;
        endcase
    end

    assign taken = is_branch & ~illegal & (cond ^ funct3[0]);

    // A load still in EX cannot be forwarded yet; x0 destinations never conflict
    assign hazard = ex_rmem_en_i & ex_wreg_en_i & (ex_wreg_addr_i != 5'd0) & if_valid_i &
                    ((use_rs1 & (ex_wreg_addr_i == rs1_addr_o)) |
                     (use_rs2 & (ex_wreg_addr_i == rs2_addr_o)));
    assign stall     = (stall_cnt != 3'd0) | hazard;
    assign out_ready = ex_ready_i | ~id_valid_o;
    assign if_ready_o = flush_i | (out_ready & ~stall);
    assign fire      = if_valid_i & if_ready_o & ~flush_i;

    assign branch_o = fire & (is_jal | is_jalr | taken);
    assign jalr_sum = rs1_fwd + imm;

    always_comb begin
        branch_target_o = '0;
        if (branch_o) begin
            if (is_jalr) begin
                branch_target_o    = jalr_sum[INST_ADDR_W-1:0];
                branch_target_o[0] = 1'b0;
            end else begin
                branch_target_o = pc_i + imm[INST_ADDR_W-1:0];
            end
        end
    end

    // The cycle that detects the hazard is itself the first bubble
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= 3'd0;
        else if (flush_i)
            stall_cnt <= 3'd0;
        else if (stall_cnt != 3'd0)
            stall_cnt <= stall_cnt - 3'd1;
        else if (hazard)
            stall_cnt <= LU_RELOAD;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid_o  <= 1'b0;
            pc_o        <= '0;
            opcode_o    <= 7'd0;
            funct3_o    <= 3'd0;
            funct7_o    <= 7'd0;
            imm_o       <= '0;
            wreg_en_o   <= 1'b0;
            wreg_addr_o <= 5'd0;
            rs1_data_o  <= '0;
            rs2_data_o  <= '0;
            wmem_en_o   <= 1'b0;
            rmem_en_o   <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (flush_i) begin
            id_valid_o <= 1'b0;
        end else if (out_ready) begin
            id_valid_o <= fire;
            if (fire) begin
                pc_o        <= pc_i;
                opcode_o    <= inst_i[6:0];
                funct3_o    <= funct3;
                funct7_o    <= inst_i[31:25];
                imm_o       <= imm;
                wreg_en_o   <= wreg_en;
                wreg_addr_o <= inst_i[11:7];
                rs1_data_o  <= rs1_fwd;
                rs2_data_o  <= rs2_fwd;
                wmem_en_o   <= is_store;
                rmem_en_o   <= is_load;
                illegal_o   <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: stimulus pushes expected ID/EX contents into a
// scoreboard, a negedge monitor pops and compares on every accepted transfer.
module tb_id_stage;

    localparam int XLEN = 32;
    localparam int AW   = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_valid_i, if_ready_o;
    logic [AW-1:0]   pc_i;
    logic [31:0]     inst_i;
    logic            flush_i, ex_ready_i, ex_rmem_en_i;
    logic            ex_wreg_en_i, mem_wreg_en_i, wb_wreg_en_i;
    logic [4:0]      ex_wreg_addr_i, mem_wreg_addr_i, wb_wreg_addr_i;
    logic [XLEN-1:0] ex_wreg_data_i, mem_wreg_data_i, wb_wreg_data_i;
    logic [4:0]      rs1_addr_o, rs2_addr_o;
    logic [XLEN-1:0] rs1_data_i, rs2_data_i;
    logic            branch_o;
    logic [AW-1:0]   branch_target_o;
    logic            id_valid_o;
    logic [AW-1:0]   pc_o;
    logic [6:0]      opcode_o;
    logic [2:0]      funct3_o;
    logic [6:0]      funct7_o;
    logic [XLEN-1:0] imm_o;
    logic            wreg_en_o;
    logic [4:0]      wreg_addr_o;
    logic [XLEN-1:0] rs1_data_o, rs2_data_o;
    logic            wmem_en_o, rmem_en_o, illegal_o;

    logic [31:0] regs [32];

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        chk_imm;
        logic        wreg_en;
        logic [4:0]  wreg_addr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        wmem;
        logic        rmem;
        logic        illegal;
    } exp_t;

    exp_t sb_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    id_stage #(.XLEN(XLEN), .INST_ADDR_W(AW), .LU_STALL_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
        .pc_i(pc_i), .inst_i(inst_i), .flush_i(flush_i),
        .ex_ready_i(ex_ready_i), .ex_rmem_en_i(ex_rmem_en_i),
        .ex_wreg_en_i(ex_wreg_en_i), .mem_wreg_en_i(mem_wreg_en_i), .wb_wreg_en_i(wb_wreg_en_i),
        .ex_wreg_addr_i(ex_wreg_addr_i), .mem_wreg_addr_i(mem_wreg_addr_i), .wb_wreg_addr_i(wb_wreg_addr_i),
        .ex_wreg_data_i(ex_wreg_data_i), .mem_wreg_data_i(mem_wreg_data_i), .wb_wreg_data_i(wb_wreg_data_i),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .branch_o(branch_o), .branch_target_o(branch_target_o),
        .id_valid_o(id_valid_o), .pc_o(pc_o),
        .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
        .imm_o(imm_o), .wreg_en_o(wreg_en_o), .wreg_addr_o(wreg_addr_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .wmem_en_o(wmem_en_o), .rmem_en_o(rmem_en_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    // Register file model; x0 deliberately returns junk so the DUT must force zero
    assign rs1_data_i = regs[rs1_addr_o];
    assign rs2_data_i = regs[rs2_addr_o];

    function automatic exp_t mkExp(
        input logic [31:0] pc, input logic [6:0] opcode, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] imm, input logic chk_imm,
        input logic wreg_en, input logic [4:0] wreg_addr,
        input logic [31:0] rs1, input logic [31:0] rs2,
        input logic wmem, input logic rmem, input logic illegal);
        exp_t e;
        e.pc = pc; e.opcode = opcode; e.f3 = f3; e.f7 = f7; e.imm = imm;
        e.chk_imm = chk_imm; e.wreg_en = wreg_en; e.wreg_addr = wreg_addr;
        e.rs1 = rs1; e.rs2 = rs2; e.wmem = wmem; e.rmem = rmem; e.illegal = illegal;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic flush);
        if_valid_i = valid;
        pc_i       = pc;
        inst_i     = inst;
        flush_i    = flush;
    endtask

    task automatic clearFwd();
        ex_rmem_en_i  = 1'b0;
        ex_wreg_en_i  = 1'b0; ex_wreg_addr_i  = 5'd0; ex_wreg_data_i  = '0;
        mem_wreg_en_i = 1'b0; mem_wreg_addr_i = 5'd0; mem_wreg_data_i = '0;
        wb_wreg_en_i  = 1'b0; wb_wreg_addr_i  = 5'd0; wb_wreg_data_i  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare only when EX actually takes the ID/EX register
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (rst_n === 1'b1 && id_valid_o === 1'b1 && ex_ready_i === 1'b1) begin
            n_compared++;
            if (sb_q.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL sb_unexpected: got instruction at pc 0x%0h, required none", pc_o);
            end else begin
                e  = sb_q.pop_front();
                ok = (pc_o === e.pc) && (opcode_o === e.opcode) && (funct3_o === e.f3) &&
                     (funct7_o === e.f7) && (!e.chk_imm || imm_o === e.imm) &&
                     (wreg_en_o === e.wreg_en) && (!e.wreg_en || wreg_addr_o === e.wreg_addr) &&
                     (rs1_data_o === e.rs1) && (rs2_data_o === e.rs2) &&
                     (wmem_en_o === e.wmem) && (rmem_en_o === e.rmem) && (illegal_o === e.illegal);
                if (!ok) begin
                    n_mismatched++;
                    $display("[TB] FAIL sb_pc_%0h: got pc=%h op=%h f3=%h f7=%h imm=%h we=%b wa=%0d rs1=%h rs2=%h wm=%b rm=%b il=%b, required pc=%h op=%h f3=%h f7=%h imm=%h(chk %b) we=%b wa=%0d rs1=%h rs2=%h wm=%b rm=%b il=%b",
                             e.pc, pc_o, opcode_o, funct3_o, funct7_o, imm_o, wreg_en_o, wreg_addr_o,
                             rs1_data_o, rs2_data_o, wmem_en_o, rmem_en_o, illegal_o,
                             e.pc, e.opcode, e.f3, e.f7, e.imm, e.chk_imm, e.wreg_en, e.wreg_addr,
                             e.rs1, e.rs2, e.wmem, e.rmem, e.illegal);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required $finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[0]  = 32'hBAD0_0000;
        regs[3]  = 32'h1111_1111;
        regs[6]  = 32'h0000_2000;
        regs[10] = 32'hFFFF_FFFF;
        regs[11] = 32'h0000_0001;

        rst_n      = 1'b0;
        ex_ready_i = 1'b1;
        clearFwd();
        applyStimulus(1'b1, 32'h100, 32'hFFF0_0293, 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_pc_imm", {pc_o, imm_o}, 64'd0);
        checkOutput("rst_fields", {42'd0, id_valid_o, opcode_o, funct3_o, funct7_o, wreg_en_o,
                                   wreg_addr_o, wmem_en_o, rmem_en_o, illegal_o}, 64'd0);
        checkOutput("rst_rsdata", {rs1_data_o, rs2_data_o}, 64'd0);

        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("rst_if_ready", 64'(if_ready_o), 64'd1);
        checkOutput("rst_id_valid", 64'(id_valid_o), 64'd0);

        // ADDI x5,x0,-1
        tick();
        applyStimulus(1'b1, 32'h100, 32'hFFF0_0293, 1'b0);
        sb_q.push_back(mkExp(32'h100, 7'h13, 3'd0, 7'h7F, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd5,
                             32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput("addi_if_ready", 64'(if_ready_o), 64'd1);
        checkOutput("addi_branch", 64'(branch_o), 64'd0);

        // Load-use: load x3 in EX, add x4,x3,x3 in ID
        tick();
        ex_rmem_en_i = 1'b1; ex_wreg_en_i = 1'b1; ex_wreg_addr_i = 5'd3; ex_wreg_data_i = 32'h5555_5555;
        applyStimulus(1'b1, 32'h104, 32'h0031_8233, 1'b0);
        @(negedge clk);
        checkOutput("lu_stall1", 64'(if_ready_o), 64'd0);

        tick();
        clearFwd();
        mem_wreg_en_i = 1'b1; mem_wreg_addr_i = 5'd3; mem_wreg_data_i = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("lu_stall2", 64'(if_ready_o), 64'd0);
        checkOutput("lu_bubble1", 64'(id_valid_o), 64'd0);

        tick();
        sb_q.push_back(mkExp(32'h104, 7'h33, 3'd0, 7'h00, 32'd0, 1'b0, 1'b1, 5'd4,
                             32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput("lu_release", 64'(if_ready_o), 64'd1);
        checkOutput("lu_bubble2", 64'(id_valid_o), 64'd0);

        // Forwarding priority on x7, then MEM over WB, then all stages on x0
        tick();
        clearFwd();
        ex_wreg_en_i  = 1'b1; ex_wreg_addr_i  = 5'd7; ex_wreg_data_i  = 32'd1;
        mem_wreg_en_i = 1'b1; mem_wreg_addr_i = 5'd7; mem_wreg_data_i = 32'd2;
        wb_wreg_en_i  = 1'b1; wb_wreg_addr_i  = 5'd7; wb_wreg_data_i  = 32'd3;
        applyStimulus(1'b1, 32'h108, 32'h0003_84B3, 1'b0);
        sb_q.push_back(mkExp(32'h108, 7'h33, 3'd0, 7'h00, 32'd0, 1'b0, 1'b1, 5'd9,
                             32'd1, 32'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput("fwd_if_ready", 64'(if_ready_o), 64'd1);

        tick();
        ex_wreg_en_i = 1'b0;
        applyStimulus(1'b1, 32'h10C, 32'h0003_84B3, 1'b0);
        sb_q.push_back(mkExp(32'h10C, 7'h33, 3'd0, 7'h00, 32'd0, 1'b0, 1'b1, 5'd9,
                             32'd2, 32'd0, 1'b0, 1'b0, 1'b0));

        tick();
        ex_rmem_en_i  = 1'b1;
        ex_wreg_en_i  = 1'b1; ex_wreg_addr_i  = 5'd0; ex_wreg_data_i  = 32'd1;
        mem_wreg_en_i = 1'b1; mem_wreg_addr_i = 5'd0; mem_wreg_data_i = 32'd2;
        wb_wreg_en_i  = 1'b1; wb_wreg_addr_i  = 5'd0; wb_wreg_data_i  = 32'd3;
        applyStimulus(1'b1, 32'h110, 32'h0000_04B3, 1'b0);
        sb_q.push_back(mkExp(32'h110, 7'h33, 3'd0, 7'h00, 32'd0, 1'b0, 1'b1, 5'd9,
                             32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput("x0_load_no_stall", 64'(if_ready_o), 64'd1);

        // JALR x1,5(x6)
        tick();
        clearFwd();
        applyStimulus(1'b1, 32'h114, 32'h0053_00E7, 1'b0);
        sb_q.push_back(mkExp(32'h114, 7'h67, 3'd0, 7'h00, 32'd5, 1'b1, 1'b1, 5'd1,
                             32'h2000, 32'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput("jalr_branch", 64'(branch_o), 64'd1);
        checkOutput("jalr_target", 64'(branch_target_o), 64'h2004);

        // BLTU x10,x11,+16 : 0xFFFFFFFF <u 1 is false
        tick();
        applyStimulus(1'b1, 32'h118, 32'h00B5_6863, 1'b0);
        sb_q.push_back(mkExp(32'h118, 7'h63, 3'd6, 7'h00, 32'd16, 1'b1, 1'b0, 5'd16,
                             32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput("bltu_branch", 64'(branch_o), 64'd0);
        checkOutput("bltu_target", 64'(branch_target_o), 64'd0);

        // BLT x10,x11,+16 : -1 < 1 is true
        tick();
        applyStimulus(1'b1, 32'h11C, 32'h00B5_4863, 1'b0);
        sb_q.push_back(mkExp(32'h11C, 7'h63, 3'd4, 7'h00, 32'd16, 1'b1, 1'b0, 5'd16,
                             32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput("blt_branch", 64'(branch_o), 64'd1);
        checkOutput("blt_target", 64'(branch_target_o), 64'h12C);

        // LUI x12,0xABCDE followed by three cycles of back-pressure
        tick();
        applyStimulus(1'b1, 32'h120, 32'hABCD_E637, 1'b0);
        sb_q.push_back(mkExp(32'h120, 7'h37, 3'd6, 7'h55, 32'hABCD_E000, 1'b1, 1'b1, 5'd12,
                             32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput("lui_if_ready", 64'(if_ready_o), 64'd1);

        for (int c = 0; c < 3; c++) begin
            tick();
            ex_ready_i = 1'b0;
            applyStimulus(1'b1, 32'h124, 32'hFFF0_0293, 1'b0);
            @(negedge clk);
            checkOutput("bp_if_ready", 64'(if_ready_o), 64'd0);
            checkOutput("bp_hold_pc", {31'd0, id_valid_o, pc_o}, {31'd0, 1'b1, 32'h120});
            checkOutput("bp_hold_imm", {27'd0, wreg_addr_o, imm_o}, {27'd0, 5'd12, 32'hABCD_E000});
        end

        tick();
        ex_ready_i = 1'b1;
        sb_q.push_back(mkExp(32'h124, 7'h13, 3'd0, 7'h7F, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd5,
                             32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput("bp_release", 64'(if_ready_o), 64'd1);

        // Flush arriving together with a load-use hazard
        tick();
        ex_rmem_en_i = 1'b1; ex_wreg_en_i = 1'b1; ex_wreg_addr_i = 5'd3;
        applyStimulus(1'b1, 32'h128, 32'h0031_8233, 1'b1);
        @(negedge clk);
        checkOutput("flush_if_ready", 64'(if_ready_o), 64'd1);
        checkOutput("flush_branch", 64'(branch_o), 64'd0);

        tick();
        clearFwd();
        applyStimulus(1'b1, 32'h130, 32'h0031_8233, 1'b0);
        sb_q.push_back(mkExp(32'h130, 7'h33, 3'd0, 7'h00, 32'd0, 1'b0, 1'b1, 5'd4,
                             32'h1111_1111, 32'h1111_1111, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput("flush_cnt_clr", 64'(if_ready_o), 64'd1);
        checkOutput("flush_kill", 64'(id_valid_o), 64'd0);

        // Flush suppresses a JALR redirect
        tick();
        applyStimulus(1'b1, 32'h134, 32'h0053_00E7, 1'b1);
        @(negedge clk);
        checkOutput("flush_jalr_branch", 64'(branch_o), 64'd0);
        checkOutput("flush_jalr_target", 64'(branch_target_o), 64'd0);

        // Illegal opcode 0x7F with rd=x5
        tick();
        applyStimulus(1'b1, 32'h138, 32'h0000_02FF, 1'b0);
        sb_q.push_back(mkExp(32'h138, 7'h7F, 3'd0, 7'h00, 32'd0, 1'b0, 1'b0, 5'd5,
                             32'd0, 32'd0, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        checkOutput("flush_kill2", 64'(id_valid_o), 64'd0);

        // SW x11,-4(x10) and LW x13,8(x6)
        tick();
        applyStimulus(1'b1, 32'h13C, 32'hFEB5_2E23, 1'b0);
        sb_q.push_back(mkExp(32'h13C, 7'h23, 3'd2, 7'h7F, 32'hFFFF_FFFC, 1'b1, 1'b0, 5'd28,
                             32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0));

        tick();
        applyStimulus(1'b1, 32'h140, 32'h0083_2683, 1'b0);
        sb_q.push_back(mkExp(32'h140, 7'h03, 3'd2, 7'h00, 32'd8, 1'b1, 1'b1, 5'd13,
                             32'h2000, 32'd0, 1'b0, 1'b1, 1'b0));

        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        checkOutput("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
